// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control types and constants for the 5-stage CPU.
// Imported by the hazard stall unit, its interface and its bench.
package cpu_pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_e;

    localparam int REG_W          = 5;
    localparam int MD_LATENCY_DEF = 4;
    localparam int STAT_W         = 16;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Hazard-control bundle: ID/EX hazard inputs in, pipeline enables and stall statistic out.
// master is the hazard unit (producer of the PC write enable); slave is the pipeline.
interface hazard_stall_unit_if
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W = cpu_pipe_pkg::REG_W
);
    logic [REG_W-1:0]  i_id_rs;
    logic [REG_W-1:0]  i_id_rt;
    logic              i_id_uses_rt;
    logic              i_id_is_md;
    logic              i_ex_mem_read;
    logic [REG_W-1:0]  i_ex_rt;
    logic              i_ex_branch_taken;
    logic              i_stat_clr;

    logic              o_pc_write;
    logic              o_if_id_write;
    logic              o_if_id_flush;
    logic              o_id_ex_write;
    logic              o_id_ex_bubble;
    logic              o_ex_mem_bubble;
    logic [STAT_W-1:0] o_stall_cycles;

    modport master (
        input  i_id_rs, i_id_rt, i_id_uses_rt, i_id_is_md,
               i_ex_mem_read, i_ex_rt, i_ex_branch_taken, i_stat_clr,
        output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_write,
               o_id_ex_bubble, o_ex_mem_bubble, o_stall_cycles
    );

    modport slave (
        output i_id_rs, i_id_rt, i_id_uses_rt, i_id_is_md,
               i_ex_mem_read, i_ex_rt, i_ex_branch_taken, i_stat_clr,
        input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_write,
               o_id_ex_bubble, o_ex_mem_bubble, o_stall_cycles
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Width-parameterized up-counter with synchronous clear, enable and saturation at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_en && (o_count != {W{1'b1}})) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stall, counted mul/div occupancy stall, branch flush.
//   state   | meaning
//   RUN     | normal flow; branch flush, load-use stall or mul/div acceptance decided per cycle
//   MD_BUSY | mul/div occupies EX; front end frozen, EX/MEM gets bubbles until cnt hits 1
module hazard_stall_unit
    import cpu_pipe_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int REG_W      = cpu_pipe_pkg::REG_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    hazard_stall_unit_if.master hif
);

    localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 1);

    hz_state_e        state;
    logic [3:0]       cnt;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] ex_rt;
    logic             lu;
    logic             md_enter;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;

    assign id_rs = hif.i_id_rs;
    assign id_rt = hif.i_id_rt;
    assign ex_rt = hif.i_ex_rt;

    assign lu = hif.i_ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (hif.i_id_uses_rt && (ex_rt == id_rt)));

    // Branch outranks load-use, which outranks mul/div acceptance; a single-cycle op never stalls.
    assign md_enter = (state == RUN) && !hif.i_ex_branch_taken && !lu &&
                      hif.i_id_is_md && (MD_LATENCY > 1);

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if (state == MD_BUSY) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
        end else if (hif.i_ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (md_enter) begin
                        state <= MD_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (cnt == 4'd1) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign hif.o_pc_write      = pc_write;
    assign hif.o_if_id_write   = if_id_write;
    assign hif.o_if_id_flush   = if_id_flush;
    assign hif.o_id_ex_write   = id_ex_write;
    assign hif.o_id_ex_bubble  = id_ex_bubble;
    assign hif.o_ex_mem_bubble = ex_mem_bubble;

    sat_counter #(
        .W (STAT_W)
    ) u_stall_stat (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (hif.i_stat_clr),
        .i_en    (!pc_write),
        .o_count (hif.o_stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: driver pushes model predictions, negedge monitor compares.
module tb_hazard_stall_unit;
    import cpu_pipe_pkg::*;

    localparam int LAT = 4;

    logic i_clk = 1'b0;
    logic i_rst_n;

    always #5 i_clk = ~i_clk;

    hazard_stall_unit_if #(.REG_W(REG_W)) hif();

    hazard_stall_unit #(
        .MD_LATENCY (LAT),
        .REG_W      (REG_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .hif     (hif.master)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       is_md;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       br;
        logic       clr;
    } stim_t;

    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble}
    typedef struct {
        logic [5:0] ctl;
        int         stat;
    } exp_t;

    localparam logic [5:0] CTL_DEF   = 6'b110100;
    localparam logic [5:0] CTL_FLUSH = 6'b111110;
    localparam logic [5:0] CTL_LU    = 6'b000110;
    localparam logic [5:0] CTL_BUSY  = 6'b000001;

    exp_t sb[$];
    int   md_left  = 0;
    int   stat_m   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic drive(input stim_t s, input logic rst_n);
        exp_t e;
        bit   lu;
        @(posedge i_clk);
        #1;
        i_rst_n               = rst_n;
        hif.i_id_rs           = s.rs;
        hif.i_id_rt           = s.rt;
        hif.i_id_uses_rt      = s.uses_rt;
        hif.i_id_is_md        = s.is_md;
        hif.i_ex_mem_read     = s.mem_read;
        hif.i_ex_rt           = s.ex_rt;
        hif.i_ex_branch_taken = s.br;
        hif.i_stat_clr        = s.clr;

        if (!rst_n) begin
            md_left = 0;
            stat_m  = 0;
        end
        lu = s.mem_read && (s.ex_rt != 0) &&
             ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
        e.stat = stat_m;
        if (md_left > 0)   e.ctl = CTL_BUSY;
        else if (s.br)     e.ctl = CTL_FLUSH;
        else if (lu)       e.ctl = CTL_LU;
        else               e.ctl = CTL_DEF;
        sb.push_back(e);

        if (rst_n) begin
            if (md_left > 0) md_left = md_left - 1;
            else if (!s.br && !lu && s.is_md && LAT > 1) md_left = LAT - 1;
            if (s.clr) stat_m = 0;
            else if (!e.ctl[5] && stat_m < 65535) stat_m = stat_m + 1;
        end
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rs       = 5'($urandom_range(0, 3));
        s.rt       = 5'($urandom_range(0, 3));
        s.uses_rt  = 1'($urandom_range(0, 1));
        s.is_md    = ($urandom_range(0, 9) == 0);
        s.mem_read = ($urandom_range(0, 9) < 4);
        s.ex_rt    = 5'($urandom_range(0, 3));
        s.br       = ($urandom_range(0, 9) == 0);
        s.clr      = ($urandom_range(0, 29) == 0);
        return s;
    endfunction

    always @(negedge i_clk) begin
        exp_t       e;
        logic [5:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {hif.o_pc_write, hif.o_if_id_write, hif.o_if_id_flush,
                   hif.o_id_ex_write, hif.o_id_ex_bubble, hif.o_ex_mem_bubble};
            n_checks++;
            if (act !== e.ctl) begin
                n_errors++;
                $display("FAIL ctl at %0t: got %b expected %b", $time, act, e.ctl);
            end
            n_checks++;
            if (hif.o_stall_cycles !== 16'(e.stat)) begin
                n_errors++;
                $display("FAIL stall_cycles at %0t: got %0d expected %0d",
                         $time, hif.o_stall_cycles, e.stat);
            end
        end
    end

    initial begin
        stim_t idle;
        stim_t s;
        idle    = '0;
        i_rst_n = 1'b0;
        hif.i_id_rs = '0; hif.i_id_rt = '0; hif.i_id_uses_rt = 1'b0; hif.i_id_is_md = 1'b0;
        hif.i_ex_mem_read = 1'b0; hif.i_ex_rt = '0; hif.i_ex_branch_taken = 1'b0; hif.i_stat_clr = 1'b0;

        drive(idle, 1'b0);
        drive(idle, 1'b0);
        drive(idle, 1'b1);
        drive(idle, 1'b1);

        // load-use on rs, then cleared inputs
        s = idle; s.mem_read = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5;
        drive(s, 1'b1);
        drive(idle, 1'b1);
        drive(idle, 1'b1);

        // load into r0 never stalls
        s = idle; s.mem_read = 1'b1; s.ex_rt = 5'd0; s.rs = 5'd0;
        drive(s, 1'b1);
        drive(idle, 1'b1);

        // rt match only counts when rt is a source
        s = idle; s.mem_read = 1'b1; s.ex_rt = 5'd7; s.rt = 5'd7; s.rs = 5'd2; s.uses_rt = 1'b1;
        drive(s, 1'b1);
        s.uses_rt = 1'b0;
        drive(s, 1'b1);

        // mul/div occupancy
        s = idle; s.is_md = 1'b1;
        drive(s, 1'b1);
        repeat (5) drive(idle, 1'b1);

        // branch beats load-use and mul/div
        s = idle; s.br = 1'b1; s.mem_read = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5; s.is_md = 1'b1;
        drive(s, 1'b1);
        drive(idle, 1'b1);

        // mul/div behind a load-use enters only when it advances
        s = idle; s.mem_read = 1'b1; s.ex_rt = 5'd3; s.rs = 5'd3; s.is_md = 1'b1;
        drive(s, 1'b1);
        s = idle; s.is_md = 1'b1;
        drive(s, 1'b1);
        repeat (5) drive(idle, 1'b1);

        // asynchronous reset in the middle of MD_BUSY
        s = idle; s.is_md = 1'b1;
        drive(s, 1'b1);
        drive(idle, 1'b1);
        drive(idle, 1'b0);
        drive(idle, 1'b1);
        drive(idle, 1'b1);

        // saturate the statistic, then clear it during a stall
        s = idle; s.mem_read = 1'b1; s.ex_rt = 5'd9; s.rs = 5'd9;
        repeat (65540) drive(s, 1'b1);
        s.clr = 1'b1;
        drive(s, 1'b1);
        drive(idle, 1'b1);
        drive(idle, 1'b1);

        repeat (3000) drive(rnd_stim(), ($urandom_range(0, 199) != 0));
        drive(idle, 1'b1);

        @(negedge i_clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d predictions left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
